// File: rtl/bnn_pkg.sv
// Shared types and width helpers for the binary conv/pool datapath.
package bnn_pkg;

    typedef enum logic [1:0] {IDLE, CONV, EMIT, DONE} conv_state_t;

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int thr_w(input int in_ch, input int k);
        return $clog2(in_ch * k * k + 1);
    endfunction

endpackage

// File: rtl/bnn_window_popcount.sv
// XNOR-popcount of one KxK window across all input planes for filter o at (r,c).
module bnn_window_popcount
    import bnn_pkg::*;
#(
    parameter int   IMG_H   = 28,
    parameter int   IMG_W   = 28,
    parameter int   IN_CH   = 1,
    parameter int   OUT_CH  = 8,
    parameter int   K       = 3,
    parameter logic PAD_VAL = 1'b0,
    parameter int   THR_W   = thr_w(IN_CH, K)
) (
    input  logic [IN_CH*IMG_H*IMG_W-1:0]   img_i,
    input  logic [OUT_CH*IN_CH*K*K-1:0]    weights_i,
    input  logic [idx_w(OUT_CH)-1:0]       o,
    input  logic [idx_w(IMG_H/2):0]        r,
    input  logic [idx_w(IMG_W/2):0]        c,
    output logic [THR_W-1:0]               popcount
);

    localparam int NTAP = IN_CH * K * K;

    logic [NTAP-1:0] match;

    for (genvar i = 0; i < IN_CH; i++) begin : g_ch
        for (genvar kr = 0; kr < K; kr++) begin : g_kr
            for (genvar kc = 0; kc < K; kc++) begin : g_kc
                localparam int T = (i * K + kr) * K + kc;
                int   tr, tc;
                logic tap;

                // Any tap falling off an edge or corner reads the pad value.
                always_comb begin
                    tr  = int'(r) + kr - K / 2;
                    tc  = int'(c) + kc - K / 2;
                    tap = PAD_VAL;
                    if (tr >= 0 && tr < IMG_H && tc >= 0 && tc < IMG_W)
                        tap = img_i[(i * IMG_H + tr) * IMG_W + tc];
                end

                assign match[T] = ~(tap ^ weights_i[int'(o) * NTAP + T]);
            end
        end
    end

    always_comb begin
        popcount = '0;
        for (int t = 0; t < NTAP; t++)
            popcount = popcount + THR_W'(match[t]);
    end

endmodule

// File: rtl/bnn_conv_pool.sv
// Binary conv layer: threshold each window popcount, 2x2 OR-pool, stream one pooled bit per handshake.
module bnn_conv_pool
    import bnn_pkg::*;
#(
    parameter int   IMG_H   = 28,
    parameter int   IMG_W   = 28,
    parameter int   IN_CH   = 1,
    parameter int   OUT_CH  = 8,
    parameter int   K       = 3,
    parameter logic PAD_VAL = 1'b0,
    parameter int   THR_W   = thr_w(IN_CH, K)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [IN_CH*IMG_H*IMG_W-1:0]   img_i,
    input  logic [OUT_CH*IN_CH*K*K-1:0]    weights_i,
    input  logic [OUT_CH*THR_W-1:0]        thresh_i,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_bit,
    output logic [idx_w(OUT_CH)-1:0]       out_ch,
    output logic [idx_w(IMG_H/2)-1:0]      out_row,
    output logic [idx_w(IMG_W/2)-1:0]      out_col,
    output logic                           busy,
    output logic                           done
);

    localparam int PH   = IMG_H / 2;
    localparam int PW   = IMG_W / 2;
    localparam int CH_W = idx_w(OUT_CH);
    localparam int PR_W = idx_w(PH);
    localparam int PC_W = idx_w(PW);

    if (IMG_H % 2 != 0 || IMG_W % 2 != 0) begin : g_bad_dims
        $fatal(1, "bnn_conv_pool: IMG_H and IMG_W must be even");
    end
    if (K < 1 || K % 2 == 0) begin : g_bad_k
        $fatal(1, "bnn_conv_pool: K must be odd and >= 1");
    end
    if ((1 << THR_W) <= IN_CH * K * K) begin : g_bad_thr
        $fatal(1, "bnn_conv_pool: THR_W too narrow for popcount");
    end

    conv_state_t      state;
    logic [1:0]       sub;
    logic             acc;
    logic [THR_W-1:0] pcnt;
    logic             cbit;
    logic [PR_W:0]    r;
    logic [PC_W:0]    c;
    logic             last_pc, last_pr, last_o;

    // sub walks the pool quad row-major: bit 1 picks the row, bit 0 the column.
    assign r = {out_row, sub[1]};
    assign c = {out_col, sub[0]};

    bnn_window_popcount #(
        .IMG_H(IMG_H), .IMG_W(IMG_W), .IN_CH(IN_CH), .OUT_CH(OUT_CH),
        .K(K), .PAD_VAL(PAD_VAL), .THR_W(THR_W)
    ) u_win (
        .img_i     (img_i),
        .weights_i (weights_i),
        .o         (out_ch),
        .r         (r),
        .c         (c),
        .popcount  (pcnt)
    );

    assign cbit    = pcnt >= thresh_i[int'(out_ch) * THR_W +: THR_W];
    assign last_pc = out_col == PC_W'(PW - 1);
    assign last_pr = out_row == PR_W'(PH - 1);
    assign last_o  = out_ch  == CH_W'(OUT_CH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sub       <= '0;
            acc       <= 1'b0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_ch    <= '0;
            out_row   <= '0;
            out_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CONV;
                        sub     <= '0;
                        acc     <= 1'b0;
                        out_ch  <= '0;
                        out_row <= '0;
                        out_col <= '0;
                        busy    <= 1'b1;
                    end
                end
                CONV: begin
                    sub <= sub + 2'd1;
                    if (sub == 2'd3) begin
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_bit   <= acc | cbit;
                        acc       <= 1'b0;
                    end else begin
                        acc <= acc | cbit;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_o && last_pr && last_pc) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= CONV;
                            if (last_pc) begin
                                out_col <= '0;
                                if (last_pr) begin
                                    out_row <= '0;
                                    out_ch  <= out_ch + 1'b1;
                                end else begin
                                    out_row <= out_row + 1'b1;
                                end
                            end else begin
                                out_col <= out_col + 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
